alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU and its ALU control decoder between two requesters: req0 is the main pipeline, req1 is an auxiliary unit such as a multi-cycle sequencer or address generator.
- Round-robin arbitration, with an optional lock that lets one requester issue back-to-back sequences.
- Registered issue stage drives the ALU's op/funct/operand inputs; a registered response stage returns the result tagged with the requester ID.
- Sits between the requesters and the ALU + ALU control pair.

Parameters:
- W, 32, operand/result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_lock  in  1  keep grant with requester 0 after this operation.
- req0_op  in  2  ALU op class (00 add, 01 sub, 10 R-type/funct).
- req0_funct  in  6  R-type funct field.
- req0_a, req0_b  in  W  operands.
- req0_gnt  out  1  operation accepted this cycle (combinational).
- req1_valid, req1_lock, req1_op, req1_funct, req1_a, req1_b, req1_gnt: same as req0, for requester 1.
- alu_op  out  2  registered, to ALU control.
- alu_funct  out  6  registered, to ALU control.
- alu_a, alu_b  out  W  registered, to ALU.
- alu_result  in  W  combinational ALU result for the current alu_* inputs.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid, 1-cycle pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  W  captured alu_result.
- rsp_zero  out  1  captured alu_zero.
- busy  out  1  issue or response stage occupied, or lock held.

Behaviour:
- Reset (rst_n low, async): all alu_*, rsp_*, busy = 0; issue-valid = 0; rr_ptr = 0 (req0 preferred); lock_held = 0, lock_owner = 0.
- Handshake: a requester holds valid and payload stable until it sees gnt high. Transfer occurs on the clock edge where valid & gnt.
- At most one gnt per cycle; gnt is never asserted without the matching valid.
- Arbitration, evaluated in order:
  - lock_held=1: only lock_owner may be granted; the other requester waits even if lock_owner is idle.
  - Else, exactly one valid: grant it.
  - Else, both valid: grant the requester selected by rr_ptr.
- rr_ptr update: on every grant, rr_ptr becomes the other requester's ID.
- Lock: on a grant with reqX_lock=1, set lock_held=1, lock_owner=X.
- Unlock: on a grant to lock_owner with lock=0, clear lock_held. That final unlocked op is still accepted.
- Stage 1 (issue), edge N (grant edge): load alu_op/alu_funct/alu_a/alu_b from the winner; iss_valid=1; iss_id=winner.
- No grant at an edge: iss_valid=0. alu_* keep their previous values (no toggling).
- Stage 2 (response), edge N+1: if iss_valid, capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_id=iss_id, rsp_valid=1; else rsp_valid=0.
- Latency: request granted in cycle N → rsp_valid high throughout cycle N+2, for exactly one cycle.
- Throughput: one operation per cycle, fully pipelined.
- No response backpressure: requesters must sink rsp_valid in the cycle it is asserted.
- Responses return in grant order; rsp_id distinguishes the owner.
- busy = iss_valid | rsp_valid | lock_held.
- Boundary conditions:
  - Both valid with rr_ptr=0: req0 granted, then req1 in the next cycle if it is still valid. Strict alternation while both are continuously valid.
  - The lock owner's valid drops while the lock is held: no grants occur; the lock persists until the owner issues an op with lock=0.
  - Both requesters assert lock simultaneously (no lock held): only the winner's lock takes effect.
  - rst_n asserted mid-operation: in-flight issue and response are discarded with no rsp_valid pulse. After deassertion the first grant follows the reset rr_ptr=0.
  - op=11 or an unknown funct is passed through unchanged; decoding is the ALU control's responsibility.

Test Plan:
- Single op: req0 valid, op=00, a=5, b=3 at cycle 1 → req0_gnt=1 in cycle 1; alu_a=5, alu_b=3, alu_op=00 in cycle 2; rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0 in cycle 3.
- Contention: both valid continuously from reset with 4 ops each → grant order 0,1,0,1,0,1,0,1; responses 2 cycles later in the same order with correct IDs.
- Lock: req1 issues a sub with lock=1 (a=7, b=7), then an slt with lock=0, while req0 is continuously valid → req0 gets no grant until after req1's unlock op; the first response has rsp_zero=1, rsp_result=0.
- Back-to-back: req0 issues 3 consecutive ops (op=10, funct=100000: 1+1, 2+2, 3+3) → rsp_valid high for 3 consecutive cycles with results 2, 4, 6.
- Reset mid-flight: rst_n low at cycle 2 while an op is in the issue stage → all outputs 0 immediately, no rsp_valid ever pulses for that op; after release with both valid, req0 is granted first.
- Idle hold: no valid for 5 cycles after an op → alu_* retain the last values, rsp_valid=0, busy=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one ALU and its ALU control decoder.
// Requester 0 is the main pipeline. Requester 1 is an auxiliary unit.
// Arbitration is round-robin. A requester may lock the grant so that it can
// issue a back-to-back sequence without the other requester interleaving.
//
// Pipeline, for a grant at edge N:
//   edge N   : the issue stage loads alu_op/alu_funct/alu_a/alu_b.
//   edge N+1 : the response stage captures alu_result/alu_zero.
//              rsp_valid then pulses for one cycle.
// There is no response backpressure.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   reqX_valid/lock         request valid; keep the grant after this op
//   reqX_op/funct/a/b       request payload
//   reqX_gnt                combinational accept, valid & gnt transfers
//   alu_op/funct/a/b        registered drive to the ALU control and the ALU
//   alu_result, alu_zero    combinational ALU outputs for the current alu_*
//   rsp_valid/id/result/zero registered response tagged with the requester
//   busy                    pipeline occupied or a lock is held
module alu_share_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req0_lock,
    input  logic [1:0]   req0_op,
    input  logic [5:0]   req0_funct,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_gnt,
    input  logic         req1_valid,
    input  logic         req1_lock,
    input  logic [1:0]   req1_op,
    input  logic [5:0]   req1_funct,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_gnt,
    output logic [1:0]   alu_op,
    output logic [5:0]   alu_funct,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         busy
);

    logic rr_ptr_q;      // requester preferred when both are valid
    logic lock_held_q;
    logic lock_owner_q;
    logic iss_valid_q;
    logic iss_id_q;

    logic gnt0, gnt1, any_gnt, win_id, win_lock;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_held_q) begin
            // The non-owner is starved even when the owner is idle.
            gnt0 = req0_valid & ~lock_owner_q;
            gnt1 = req1_valid & lock_owner_q;
        end else if (req0_valid && req1_valid) begin
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_gnt = gnt0;
    assign req1_gnt = gnt1;
    assign any_gnt  = gnt0 | gnt1;
    assign win_id   = gnt1;
    assign win_lock = gnt1 ? req1_lock : req0_lock;

    // Arbitration state.
    // A grant with lock=0 releases the lock, whoever held it.
    // A non-owner can never be granted while the lock is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= 1'b0;
            lock_held_q  <= 1'b0;
            lock_owner_q <= 1'b0;
        end else if (any_gnt) begin
            rr_ptr_q    <= ~win_id;
            lock_held_q <= win_lock;
            if (win_lock) begin
                lock_owner_q <= win_id;
            end
        end
    end

    // Issue stage. The alu_* outputs hold their values on idle cycles.
    // This avoids needless toggling of the ALU inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            alu_op      <= 2'b00;
            alu_funct   <= 6'd0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else begin
            iss_valid_q <= any_gnt;
            if (any_gnt) begin
                iss_id_q  <= win_id;
                alu_op    <= gnt1 ? req1_op    : req0_op;
                alu_funct <= gnt1 ? req1_funct : req0_funct;
                alu_a     <= gnt1 ? req1_a     : req0_a;
                alu_b     <= gnt1 ? req1_b     : req0_b;
            end
        end
    end

    // Response stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            rsp_valid <= iss_valid_q;
            if (iss_valid_q) begin
                rsp_id     <= iss_id_q;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

    assign busy = iss_valid_q | rsp_valid | lock_held_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter.
// A small ALU model drives alu_result and alu_zero.
// A driver process presents the per-requester op queues and records each grant.
// A monitor process checks every response against the scoreboard queue.
module tb_alu_share_arbiter;
    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         lock;
        int           delay;   // idle cycles before this op is presented
        logic [W-1:0] res;
        logic         zero;
    } op_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
        int           gcyc;
    } exp_t;

    logic         clk, rst_n;
    logic         req0_valid, req0_lock, req0_gnt;
    logic [1:0]   req0_op;
    logic [5:0]   req0_funct;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_lock, req1_gnt;
    logic [1:0]   req1_op;
    logic [5:0]   req1_funct;
    logic [W-1:0] req1_a, req1_b;
    logic [1:0]   alu_op;
    logic [5:0]   alu_funct;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         rsp_valid, rsp_id, rsp_zero, busy;
    logic [W-1:0] rsp_result;

    op_t  q0[$];
    op_t  q1[$];
    exp_t exp_q[$];
    bit   glog[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    alu_share_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_op(req0_op),
        .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b), .req0_gnt(req0_gnt),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_op(req1_op),
        .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b), .req1_gnt(req1_gnt),
        .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model. op=11 returns a^b, so that pass-through of op=11 is visible.
    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: begin
                case (alu_funct)
                    6'h20:   alu_result = alu_a + alu_b;
                    6'h22:   alu_result = alu_a - alu_b;
                    6'h24:   alu_result = alu_a & alu_b;
                    6'h25:   alu_result = alu_a | alu_b;
                    6'h2a:   alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add_op(input bit side, input logic [1:0] op, input logic [5:0] funct,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic lock,
                          input int delay, input logic [W-1:0] res, input logic zero);
        op_t o;
        o.op = op; o.funct = funct; o.a = a; o.b = b; o.lock = lock;
        o.delay = delay; o.res = res; o.zero = zero;
        if (side) q1.push_back(o);
        else q0.push_back(o);
    endtask

    // Driver: presents the ops at the negedge and samples the grants just before the posedge.
    initial begin : driver
        int  wait0, wait1;
        bit  armed0, armed1, pend;
        op_t iss, o;
        exp_t e;
        wait0 = 0; wait1 = 0; armed0 = 0; armed1 = 0; pend = 0;
        req0_valid = 0; req0_lock = 0; req0_op = 0; req0_funct = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_lock = 0; req1_op = 0; req1_funct = 0; req1_a = 0; req1_b = 0;
        forever begin
            @(negedge clk);
            if (pend && rst_n) begin
                checks++;
                if (alu_op !== iss.op || alu_funct !== iss.funct ||
                    alu_a !== iss.a || alu_b !== iss.b) begin
                    failures++;
                    $display("FAIL issue_stage actual op=%0h f=%0h a=%0h b=%0h required op=%0h f=%0h a=%0h b=%0h",
                             alu_op, alu_funct, alu_a, alu_b, iss.op, iss.funct, iss.a, iss.b);
                end
            end
            pend = 0;
            if (q0.size() == 0) armed0 = 0;
            if (q1.size() == 0) armed1 = 0;
            req0_valid = 0;
            if (q0.size() > 0) begin
                if (!armed0) begin wait0 = q0[0].delay; armed0 = 1; end
                if (wait0 > 0) wait0--;
                else begin
                    req0_valid = 1; req0_lock = q0[0].lock; req0_op = q0[0].op;
                    req0_funct = q0[0].funct; req0_a = q0[0].a; req0_b = q0[0].b;
                end
            end
            req1_valid = 0;
            if (q1.size() > 0) begin
                if (!armed1) begin wait1 = q1[0].delay; armed1 = 1; end
                if (wait1 > 0) wait1--;
                else begin
                    req1_valid = 1; req1_lock = q1[0].lock; req1_op = q1[0].op;
                    req1_funct = q1[0].funct; req1_a = q1[0].a; req1_b = q1[0].b;
                end
            end
            #4;
            if (rst_n) begin
                checks++;
                if ((req0_gnt && req1_gnt) || (req0_gnt && !req0_valid) ||
                    (req1_gnt && !req1_valid)) begin
                    failures++;
                    $display("FAIL gnt_legal actual gnt0=%0b gnt1=%0b v0=%0b v1=%0b required at most one, only with valid",
                             req0_gnt, req1_gnt, req0_valid, req1_valid);
                end
                if (req0_gnt && req0_valid && q0.size() > 0) begin
                    o = q0.pop_front(); armed0 = 0;
                    e.id = 0; e.res = o.res; e.zero = o.zero; e.gcyc = cyc;
                    exp_q.push_back(e); glog.push_back(1'b0); iss = o; pend = 1;
                end else if (req1_gnt && req1_valid && q1.size() > 0) begin
                    o = q1.pop_front(); armed1 = 0;
                    e.id = 1; e.res = o.res; e.zero = o.zero; e.gcyc = cyc;
                    exp_q.push_back(e); glog.push_back(1'b1); iss = o; pend = 1;
                end
            end
        end
    end

    // Monitor: each response must match the scoreboard head and arrive exactly two cycles after its grant.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected actual id=%0d result=%0h required no response",
                             rsp_id, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.zero ||
                        cyc != e.gcyc + 2) begin
                        failures++;
                        $display("FAIL rsp actual id=%0d res=%0h z=%0b cyc=%0d required id=%0d res=%0h z=%0b cyc=%0d",
                                 rsp_id, rsp_result, rsp_zero, cyc, e.id, e.res, e.zero, e.gcyc + 2);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete(); glog.delete();
        #1;
        chk("reset_alu_op", {30'd0, alu_op}, 0);
        chk("reset_alu_funct", {26'd0, alu_funct}, 0);
        chk("reset_alu_ab", alu_a | alu_b, 0);
        chk("reset_rsp", {rsp_result[W-4:0], rsp_valid, rsp_id, rsp_zero}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
            #2;
        end
        chk(name, q0.size() + q1.size() + exp_q.size(), 0);
    endtask

    task automatic chk_order(input string name, input logic [15:0] seq, input int n);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < glog.size() && i < 16; i++) got[i] = glog[i];
        checks++;
        if (glog.size() != n || got !== seq) begin
            failures++;
            $display("FAIL %s actual n=%0d order=%b required n=%0d order=%b",
                     name, glog.size(), got, n, seq);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_n = 1'b1;
        #2;

        // Single op, then idle hold.
        do_reset();
        add_op(0, 2'b00, 6'd0, 5, 3, 0, 0, 8, 0);
        drain("single_drain");
        chk_order("single_order", 16'b0, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("idle_alu_a", alu_a, 5);
        chk("idle_alu_b", alu_b, 3);
        chk("idle_alu_op", {30'd0, alu_op}, 0);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // Contention with strict alternation. This includes op=11 and R-type pass-through.
        do_reset();
        add_op(0, 2'b00, 6'd0, 1, 2, 0, 0, 3, 0);
        add_op(0, 2'b01, 6'd0, 10, 4, 0, 0, 6, 0);
        add_op(0, 2'b00, 6'd0, 0, 0, 0, 0, 0, 1);
        add_op(0, 2'b10, 6'h20, 100, 1, 0, 0, 101, 0);
        add_op(1, 2'b01, 6'd0, 3, 3, 0, 0, 0, 1);
        add_op(1, 2'b00, 6'd0, 7, 8, 0, 0, 15, 0);
        add_op(1, 2'b11, 6'h3f, 32'hf0, 32'h0f, 0, 0, 32'hff, 0);
        add_op(1, 2'b10, 6'h22, 20, 5, 0, 0, 15, 0);
        drain("contend_drain");
        chk_order("contend_order", 16'b10101010, 8);

        // req1 locks (sub 7-7), idles while locked, then unlocks (slt). req0 must wait.
        do_reset();
        add_op(1, 2'b01, 6'd0, 7, 7, 1, 0, 0, 1);
        add_op(1, 2'b10, 6'h2a, 3, 9, 0, 3, 1, 0);
        add_op(0, 2'b00, 6'd0, 2, 2, 0, 1, 4, 0);
        drain("lock_drain");
        chk_order("lock_order", 16'b011, 3);

        // Both assert lock together: only the winner's lock takes effect.
        do_reset();
        add_op(0, 2'b00, 6'd0, 1, 1, 1, 0, 2, 0);
        add_op(0, 2'b00, 6'd0, 2, 2, 0, 2, 4, 0);
        add_op(1, 2'b00, 6'd0, 5, 5, 1, 0, 10, 0);
        drain("duallock_drain");
        chk_order("duallock_order", 16'b100, 3);
        chk("lock_idle_busy", {31'd0, busy}, 1);
        add_op(0, 2'b00, 6'd0, 3, 4, 0, 0, 7, 0);
        repeat (4) @(negedge clk);
        #2;
        chk("lock_starves_req0", glog.size(), 3);
        add_op(1, 2'b01, 6'd0, 9, 4, 0, 0, 5, 0);
        drain("unlock_drain");
        chk_order("unlock_order", 16'b01100, 5);

        // Back-to-back R-type adds.
        do_reset();
        add_op(0, 2'b10, 6'h20, 1, 1, 0, 0, 2, 0);
        add_op(0, 2'b10, 6'h20, 2, 2, 0, 0, 4, 0);
        add_op(0, 2'b10, 6'h20, 3, 3, 0, 0, 6, 0);
        drain("b2b_drain");
        chk_order("b2b_order", 16'b000, 3);

        // Reset while an op sits in the issue stage.
        do_reset();
        add_op(0, 2'b00, 6'd0, 9, 9, 0, 0, 18, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (glog.size() == 1) break;
        end
        chk("midflight_granted", glog.size(), 1);
        #1;
        chk("midflight_busy", {31'd0, busy}, 1);
        do_reset();
        repeat (4) @(negedge clk);
        add_op(0, 2'b00, 6'd0, 1, 0, 0, 0, 1, 0);
        add_op(1, 2'b00, 6'd0, 2, 0, 0, 0, 2, 0);
        drain("post_reset_drain");
        chk_order("post_reset_order", 16'b10, 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
